mmio_seq_if: RTL and testbench

Second-generation MCU register interface for the fuzzy coprocessor core, with a parametrised data width and membership-set geometry.
- Sample FIFO: the MCU queues (T, dT) pairs here.
- Sequencer: feeds queued samples to the core, one START per sample, and collects each G result into a result FIFO.
- Readback: all config registers are readable. Sticky error flags and an interrupt cover completion, overflow, underflow and timeout.
- Placement: sits between the 8-bit MCU bus and top_coprocessor, replacing the plain register shadow.

---
 rtl/mmio_seq_pkg.sv | 59 +++++
 rtl/mmio_seq_if_sync_fifo.sv | 53 +++++
 rtl/mmio_seq_if.sv | 213 +++++++++++++++++++++
 tb/tb_mmio_seq_if.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_seq_pkg.sv
// Shared definitions for the MCU-side register interface of the fuzzy coprocessor:
// register addresses, CTRL/STATUS bit positions, sequencer states and the
// reset-time membership threshold pattern.
package mmio_seq_pkg;

  localparam logic [7:0] ADDR_STATUS   = 8'h00;
  localparam logic [7:0] ADDR_CTRL     = 8'h01;
  localparam logic [7:0] ADDR_T_STAGE  = 8'h02;
  localparam logic [7:0] ADDR_DT_STAGE = 8'h03;
  localparam logic [7:0] ADDR_G        = 8'h04;
  localparam logic [7:0] ADDR_PUSH     = 8'h05;
  localparam logic [7:0] ADDR_CLR      = 8'h06;
  localparam logic [7:0] ADDR_THR_BASE = 8'h10;

  localparam int CTRL_START    = 0;
  localparam int CTRL_REG_MODE = 1;
  localparam int CTRL_DT_MODE  = 2;
  localparam int CTRL_INIT     = 3;
  localparam int CTRL_AUTO     = 4;
  localparam int CTRL_IRQ_EN   = 5;
  localparam int CTRL_FLUSH    = 6;

  localparam int ST_DONE   = 0;
  localparam int ST_BUSY   = 1;
  localparam int ST_SEMPTY = 2;
  localparam int ST_SFULL  = 3;
  localparam int ST_REMPTY = 4;
  localparam int ST_OVF    = 5;
  localparam int ST_UDF    = 6;
  localparam int ST_TMO    = 7;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} seq_state_t;

  // Reset trapezoid corners (a,b,c,d) for neg/zero/pos; any further set is 0.
  function automatic logic [7:0] default_thr(input int set, input int corner);
    logic [7:0] v;
    v = 8'h00;
    case (set)
      0: case (corner)
           0, 1:    v = 8'h80;
           2:       v = 8'hC0;
           default: v = 8'h00;
         endcase
      1: case (corner)
           0:       v = 8'hC0;
           3:       v = 8'h40;
           default: v = 8'h00;
         endcase
      2: case (corner)
           0:       v = 8'h00;
           1:       v = 8'h40;
           default: v = 8'h80;
         endcase
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mmio_seq_if_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head.
// Ports: clk, rst_n (async, active-low); push/pop/flush strobes; din in;
//        dout = current head (valid when !empty); full/empty flags.
// Push while full and pop while empty are ignored; flush wins over both.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;
  logic         do_push, do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wp[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/mmio_seq_if.sv
// MCU register interface and sample sequencer for the fuzzy coprocessor core.
// Bus side: cs/rd/wr/addr/wdata in, combinational rdata out.
// Core side: start/init pulses, reg_mode/dt_mode, T_in/dT_in, thr_flat out;
//            valid/G_out in. irq is a registered level interrupt.
//
// state   | meaning
// IDLE    | waiting for START (AUTO=0) or a queued sample (AUTO=1)
// ISSUE   | start pulse high, T_in/dT_in already loaded, timeout armed
// WAIT    | waiting for valid rising edge or timeout
// CAPTURE | push G_out into result FIFO, set DONE
module mmio_seq_if
  import mmio_seq_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int N_IN        = 2,
  parameter int N_SETS      = 3,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cs,
  input  logic                           rd,
  input  logic                           wr,
  input  logic [7:0]                     addr,
  input  logic [DATA_W-1:0]              wdata,
  output logic [DATA_W-1:0]              rdata,
  output logic                           start,
  output logic                           init,
  output logic                           reg_mode,
  output logic                           dt_mode,
  output logic [DATA_W-1:0]              T_in,
  output logic [DATA_W-1:0]              dT_in,
  output logic [N_IN*N_SETS*4*DATA_W-1:0] thr_flat,
  input  logic                           valid,
  input  logic [DATA_W-1:0]              G_out,
  output logic                           irq
);
  localparam int N_THR = N_IN * N_SETS * 4;
  localparam int CW    = $clog2(TIMEOUT_CYC + 1);

  seq_state_t        state, state_n;
  logic [CW-1:0]     tmo_cnt;
  logic              valid_q, valid_rise, rd_q, rd_pulse, wr_en;
  logic              auto_en, irq_en;
  logic [DATA_W-1:0] t_stage, dt_stage;
  logic [DATA_W-1:0] thr [N_THR];
  logic [7:0]        thr_idx;
  logic              thr_hit;
  logic              done, ovf, udf, tmo;
  logic              ctrl_wr, start_req, init_req, flush_req, clr_wr;
  logic              load_fifo, load_stage, tmo_set, cap;
  logic              sf_push, sf_full, sf_empty, rf_pop, rf_full, rf_empty;
  logic [2*DATA_W-1:0] sf_dout;
  logic [DATA_W-1:0] rf_dout;
  logic [7:0]        status, ctrl_rd;

  // Reads act only on the first cycle of a cs&&rd assertion.
  assign rd_pulse   = cs && rd && !rd_q;
  assign wr_en      = cs && wr;
  assign valid_rise = valid && !valid_q;
  assign thr_idx    = addr - ADDR_THR_BASE;
  assign thr_hit    = (addr >= ADDR_THR_BASE) && (thr_idx < 8'(N_THR));

  assign ctrl_wr   = wr_en && (addr == ADDR_CTRL);
  assign start_req = ctrl_wr && wdata[CTRL_START];
  assign init_req  = ctrl_wr && wdata[CTRL_INIT];
  assign flush_req = ctrl_wr && wdata[CTRL_FLUSH] && (state == IDLE);
  assign clr_wr    = wr_en && (addr == ADDR_CLR);
  assign sf_push   = wr_en && (addr == ADDR_PUSH);
  assign rf_pop    = rd_pulse && (addr == ADDR_G);
  assign start     = (state == ISSUE);

  sync_fifo #(.W(2*DATA_W), .DEPTH(DEPTH)) u_sfifo (
    .clk(clk), .rst_n(rst_n), .push(sf_push), .pop(load_fifo), .flush(flush_req),
    .din({t_stage, dt_stage}), .dout(sf_dout), .full(sf_full), .empty(sf_empty)
  );

  sync_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_rfifo (
    .clk(clk), .rst_n(rst_n), .push(cap), .pop(rf_pop), .flush(flush_req),
    .din(G_out), .dout(rf_dout), .full(rf_full), .empty(rf_empty)
  );

  always_comb begin
    state_n    = state;
    load_fifo  = 1'b0;
    load_stage = 1'b0;
    tmo_set    = 1'b0;
    cap        = 1'b0;
    case (state)
      IDLE: begin
        if (!init_req && !flush_req) begin
          if (auto_en && !sf_empty) begin
            load_fifo = 1'b1;
            state_n   = ISSUE;
          end else if (!auto_en && start_req) begin
            load_stage = 1'b1;
            state_n    = ISSUE;
          end
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (valid_rise) begin
          state_n = CAPTURE;
        end else if (tmo_cnt == '0) begin
          tmo_set = 1'b1;
          state_n = IDLE;
        end
      end
      CAPTURE: begin
        cap     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (init_req) begin
      state_n = IDLE;
      tmo_set = 1'b0;
      cap     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tmo_cnt  <= '0;
      valid_q  <= 1'b0;
      rd_q     <= 1'b0;
      T_in     <= '0;
      dT_in    <= '0;
      init     <= 1'b0;
      irq      <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
      tmo      <= 1'b0;
    end else begin
      state   <= state_n;
      valid_q <= valid;
      rd_q    <= cs && rd;
      init    <= init_req;
      // Down-counter: 64 WAIT cycles elapse before the terminal count fires.
      if (state == ISSUE)
        tmo_cnt <= CW'(TIMEOUT_CYC - 1);
      else if (state == WAIT && tmo_cnt != '0)
        tmo_cnt <= tmo_cnt - 1'b1;
      if (load_fifo) begin
        T_in  <= sf_dout[2*DATA_W-1:DATA_W];
        dT_in <= sf_dout[DATA_W-1:0];
      end else if (load_stage) begin
        T_in  <= t_stage;
        dT_in <= dt_stage;
      end
      // Set beats a simultaneous W1C.
      done <= (done && !(clr_wr && wdata[ST_DONE])) || cap;
      ovf  <= (ovf && !(clr_wr && wdata[ST_OVF])) || (sf_push && sf_full) || (cap && rf_full);
      udf  <= (udf && !(clr_wr && wdata[ST_UDF])) || (rf_pop && rf_empty);
      tmo  <= (tmo && !(clr_wr && wdata[ST_TMO])) || tmo_set;
      irq  <= irq_en && (done || ovf || udf || tmo);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_mode <= 1'b1;
      dt_mode  <= 1'b1;
      auto_en  <= 1'b0;
      irq_en   <= 1'b0;
      t_stage  <= '0;
      dt_stage <= '0;
      for (int k = 0; k < N_THR; k++)
        thr[k] <= DATA_W'($signed(default_thr((k / 4) % N_SETS, k % 4)));
    end else if (wr_en) begin
      if (addr == ADDR_CTRL) begin
        reg_mode <= wdata[CTRL_REG_MODE];
        dt_mode  <= wdata[CTRL_DT_MODE];
        auto_en  <= wdata[CTRL_AUTO];
        irq_en   <= wdata[CTRL_IRQ_EN];
      end
      if (addr == ADDR_T_STAGE) t_stage <= wdata;
      if (addr == ADDR_DT_STAGE && !dt_mode) dt_stage <= wdata;
      for (int k = 0; k < N_THR; k++)
        if (thr_hit && thr_idx == 8'(k)) thr[k] <= wdata;
    end
  end

  always_comb begin
    thr_flat = '0;
    for (int k = 0; k < N_THR; k++) thr_flat[k*DATA_W +: DATA_W] = thr[k];
  end

  assign status  = {tmo, udf, ovf, rf_empty, sf_full, sf_empty, (state != IDLE), done};
  assign ctrl_rd = {1'b0, 1'b0, irq_en, auto_en, 1'b0, dt_mode, reg_mode, 1'b0};

  always_comb begin
    rdata = '0;
    if (cs && rd) begin
      case (addr)
        ADDR_STATUS:   rdata = DATA_W'(status);
        ADDR_CTRL:     rdata = DATA_W'(ctrl_rd);
        ADDR_T_STAGE:  rdata = t_stage;
        ADDR_DT_STAGE: rdata = dt_stage;
        ADDR_G:        rdata = rf_empty ? '0 : rf_dout;
        default: begin
          for (int k = 0; k < N_THR; k++)
            if (thr_hit && thr_idx == 8'(k)) rdata = thr[k];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_seq_if.sv
module tb_mmio_seq_if;
  import mmio_seq_pkg::*;

  localparam int DEPTH = 4;
  localparam int NTHR  = 24;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [7:0]   addr = 8'h00, wdata = 8'h00;
  logic [7:0]   rdata, T_in, dT_in, G_out;
  logic         start, init, reg_mode, dt_mode, irq;
  logic         valid = 1'b0;
  logic [191:0] thr_flat;

  mmio_seq_if dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .start(start), .init(init), .reg_mode(reg_mode), .dt_mode(dt_mode),
    .T_in(T_in), .dT_in(dT_in), .thr_flat(thr_flat), .valid(valid), .G_out(G_out), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int start_cnt = 0, init_cnt = 0;
  logic [15:0] exp_smp [$];
  logic [7:0]  exp_g [$];
  logic [15:0] mon_s;
  logic        core_en = 1'b1;
  logic [7:0]  core_g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] g_of(input logic [7:0] t);
    int v;
    v = (int'(t) * 5) / 2;
    return v[7:0];
  endfunction

  function automatic logic [7:0] thr_def(input int k);
    case (k % 12)
      0, 1:   return 8'h80;
      2:      return 8'hC0;
      4:      return 8'hC0;
      7:      return 8'h40;
      9:      return 8'h40;
      10, 11: return 8'h80;
      default: return 8'h00;
    endcase
  endfunction

  // Start monitor: every start pulse must present the next expected sample.
  always @(negedge clk) begin
    if (rst_n) begin
      if (start) begin
        start_cnt++;
        if (exp_smp.size() > 0) begin
          mon_s = exp_smp.pop_front();
          chk("start_t", T_in, mon_s[15:8]);
          chk("start_dt", dT_in, mon_s[7:0]);
        end else begin
          chk("start_unexpected", exp_smp.size(), 1);
        end
      end
      if (init) init_cnt++;
    end
  end

  // Core model: result valid two cycles after start, held for two cycles.
  always @(negedge clk) begin
    if (rst_n && start && core_en) begin
      core_g = g_of(T_in);
      @(negedge clk);
      @(negedge clk);
      G_out = core_g;
      valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      valid = 1'b0;
    end
  end

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = a;
    #1 d = rdata;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic push_smp(input logic [7:0] t, input logic [7:0] dt);
    bus_wr(ADDR_T_STAGE, t);
    bus_wr(ADDR_DT_STAGE, dt);
    bus_wr(ADDR_PUSH, 8'h00);
  endtask

  task automatic wait_idle(input string tag);
    logic [7:0] st;
    st = 8'hFF;
    for (int i = 0; i < 100; i++) begin
      bus_rd(ADDR_STATUS, st);
      if (!st[ST_BUSY] && st[ST_SEMPTY]) break;
    end
    chk(tag, st & 8'h06, 8'h04);
  endtask

  task automatic wait_start(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (start) break;
      @(negedge clk);
    end
    chk(tag, start, 1);
  endtask

  initial begin
    logic [7:0] d;
    int base, n;
    G_out = 8'h00;
    #12 rst_n = 1'b1;

    // 1: reset state and register readback
    bus_rd(ADDR_STATUS, d);   chk("rst_status", d, 8'h14);
    bus_rd(ADDR_CTRL, d);     chk("rst_ctrl", d, 8'h06);
    chk("rst_modes", {reg_mode, dt_mode, start, init, irq}, 5'b11000);
    chk("rst_tin", {T_in, dT_in}, 16'h0000);
    for (int k = 0; k < NTHR; k++) begin
      bus_rd(8'(ADDR_THR_BASE + k), d);
      chk($sformatf("thr_def_%0d", k), d, thr_def(k));
    end
    bus_wr(8'h15, 8'h5A);
    bus_rd(8'h15, d);         chk("thr_rw", d, 8'h5A);
    chk("thr_flat5", thr_flat[47:40], 8'h5A);
    bus_wr(8'h28, 8'h77);
    bus_rd(8'h28, d);         chk("thr_oob", d, 8'h00);
    bus_wr(ADDR_DT_STAGE, 8'h33);
    bus_rd(ADDR_DT_STAGE, d); chk("dt_ignored", d, 8'h00);

    // 2: auto sequencing of three queued samples
    bus_wr(ADDR_CTRL, 8'h12);
    base = start_cnt;
    exp_smp.push_back(16'h10F0); exp_g.push_back(g_of(8'h10));
    exp_smp.push_back(16'h2000); exp_g.push_back(g_of(8'h20));
    exp_smp.push_back(16'h3010); exp_g.push_back(g_of(8'h30));
    push_smp(8'h10, 8'hF0);
    push_smp(8'h20, 8'h00);
    push_smp(8'h30, 8'h10);
    wait_idle("auto_idle");
    chk("auto_starts", start_cnt - base, 3);
    for (int i = 0; i < 3; i++) begin
      bus_rd(ADDR_G, d);
      chk("g_auto", d, exp_g.pop_front());
    end
    bus_rd(ADDR_G, d);        chk("g_empty", d, 8'h00);
    bus_rd(ADDR_STATUS, d);   chk("udf_set", d[ST_UDF], 1);
    chk("done_set", d[ST_DONE], 1);
    bus_wr(ADDR_CLR, 8'hFF);

    // 3: overflow of the sample FIFO with AUTO=0, then drain
    bus_wr(ADDR_CTRL, 8'h02);
    for (int k = 0; k <= DEPTH; k++) begin
      if (k < DEPTH) begin
        exp_smp.push_back({8'(k + 1), 8'(k + 8'h60)});
        exp_g.push_back(g_of(8'(k + 1)));
      end
      push_smp(8'(k + 1), 8'(k + 8'h60));
    end
    bus_rd(ADDR_STATUS, d);   chk("ovf_status", d, 8'h38);
    base = start_cnt;
    bus_wr(ADDR_CTRL, 8'h12);
    wait_idle("ovf_drain_idle");
    chk("ovf_starts", start_cnt - base, DEPTH);
    bus_wr(ADDR_CTRL, 8'h02);
    for (int i = 0; i < DEPTH; i++) begin
      bus_rd(ADDR_G, d);
      chk("g_ovf", d, exp_g.pop_front());
    end
    bus_wr(ADDR_CLR, 8'hFF);

    // 4: timeout with valid held low
    core_en = 1'b0;
    exp_smp.push_back({8'(DEPTH + 1), 8'(DEPTH + 8'h60)});
    bus_wr(ADDR_CTRL, 8'h03);
    wait_start("tmo_start");
    repeat (60) @(negedge clk);
    bus_rd(ADDR_STATUS, d);   chk("tmo_still_wait", d, 8'h16);
    repeat (5) @(negedge clk);
    bus_rd(ADDR_STATUS, d);   chk("tmo_status", d, 8'h94);
    bus_wr(ADDR_CLR, 8'hFF);
    bus_rd(ADDR_STATUS, d);   chk("clr_all", d, 8'h14);

    // 5: interrupt latency and W1C
    core_en = 1'b1;
    bus_wr(ADDR_T_STAGE, 8'h22);
    exp_smp.push_back({8'h22, 8'(DEPTH + 8'h60)});
    exp_g.push_back(g_of(8'h22));
    bus_wr(ADDR_CTRL, 8'h23);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (valid) break;
    end
    chk("irq_pre", {valid, irq}, 2'b10);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      n++;
      if (irq) break;
    end
    chk("irq_latency", n, 3);
    bus_wr(ADDR_CLR, 8'h01);
    chk("irq_hold", irq, 1);
    @(negedge clk); #1;
    chk("irq_drop", irq, 0);
    bus_rd(ADDR_G, d);        chk("g_irq", d, exp_g.pop_front());

    // 6: INIT during WAIT keeps FIFO contents, then reset during ISSUE
    bus_wr(ADDR_CTRL, 8'h02);
    bus_wr(ADDR_CLR, 8'hFF);
    push_smp(8'h41, 8'h05);
    push_smp(8'h42, 8'h06);
    core_en = 1'b0;
    exp_smp.push_back(16'h4206);
    bus_wr(ADDR_CTRL, 8'h03);
    wait_start("init_start");
    repeat (5) @(negedge clk);
    base = init_cnt;
    bus_wr(ADDR_CTRL, 8'h0A);
    @(negedge clk); #1;
    chk("init_pulse", init_cnt - base, 1);
    bus_rd(ADDR_STATUS, d);   chk("init_status", d, 8'h10);
    core_en = 1'b1;
    exp_smp.push_back(16'h4105); exp_g.push_back(g_of(8'h41));
    exp_smp.push_back(16'h4206); exp_g.push_back(g_of(8'h42));
    bus_wr(ADDR_CTRL, 8'h12);
    wait_idle("init_drain_idle");
    bus_wr(ADDR_CTRL, 8'h02);
    for (int i = 0; i < 2; i++) begin
      bus_rd(ADDR_G, d);
      chk("g_kept", d, exp_g.pop_front());
    end
    core_en = 1'b0;
    exp_smp.push_back(16'h4206);
    bus_wr(ADDR_CTRL, 8'h03);
    chk("issue_start", start, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctl", {start, init, irq, reg_mode, dt_mode}, 5'b00011);
    chk("arst_tin", {T_in, dT_in}, 16'h0000);
    chk("arst_thr", {thr_flat[47:40], thr_flat[23:16], thr_flat[7:0]}, 24'h00C080);
    @(negedge clk);
    rst_n = 1'b1;
    bus_rd(ADDR_STATUS, d);   chk("post_rst_status", d, 8'h14);
    bus_rd(ADDR_CTRL, d);     chk("post_rst_ctrl", d, 8'h06);
    bus_rd(ADDR_T_STAGE, d);  chk("post_rst_tstage", d, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
